// File: rtl/mux2_bus_arbiter_pkg.sv
// mux2_bus_arbiter_pkg: shared FSM encoding and sizing for the mux2 bus arbiter
package mux2_bus_arbiter_pkg;
  localparam int MAX_BURST_DEF = 4;
  localparam int BURST_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_e;
endpackage

// File: rtl/mux2_bus_arbiter_mux2.sv
// mux2_bus_arbiter_mux2: 2:1 datapath mux cell, s=0 selects a, s=1 selects b
module mux2_bus_arbiter_mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? b : a;
endmodule

// File: rtl/mux2_bus_arbiter.sv
// mux2_bus_arbiter: round-robin burst-limited arbiter driving a shared 2:1 mux into one registered output
module mux2_bus_arbiter
  import mux2_bus_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);
  state_e               state_q, state_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 last_q, last_d;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic                 out_src_q;
  logic [WIDTH-1:0]     mux_y;
  logic                 granted, own, own_valid, oth_valid, out_free, xfer, rel, pick;

  mux2_bus_arbiter_mux2 #(.WIDTH(WIDTH)) u_mux (
    .a(req0_data),
    .b(req1_data),
    .s(sel),
    .y(mux_y)
  );

  assign granted   = state_q == ST_GRANT0 || state_q == ST_GRANT1;
  assign own       = state_q == ST_GRANT1;
  assign own_valid = own ? req1_valid : req0_valid;
  assign oth_valid = own ? req0_valid : req1_valid;
  assign out_free  = !out_valid_q || out_ready;
  assign xfer      = granted && own_valid && out_free;
  // a stalled grant keeps its valid high, so backpressure alone never releases it
  assign rel       = granted && (!own_valid || (xfer && burst_q == BURST_W'(MAX_BURST - 1)));
  assign pick      = (req0_valid && req1_valid) ? !last_q : req1_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      burst_q     <= '0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mux_y;
        out_src_q   <= own;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = (state_q == ST_IDLE) ? ((req0_valid || req1_valid) ? (pick ? ST_GRANT1 : ST_GRANT0) : ST_IDLE)
            : !granted ? ST_IDLE
            : rel ? (oth_valid ? (own ? ST_GRANT0 : ST_GRANT1) : ST_IDLE)
            : state_q;
    burst_d = rel ? '0 : xfer ? burst_q + 1'b1 : burst_q;
    last_d  = rel ? own : last_q;
  end

  always_comb begin
    sel        = own;
    req0_ready = state_q == ST_GRANT0 && out_free;
    req1_ready = own && out_free;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
endmodule

// File: tb/tb_mux2_bus_arbiter.sv
// tb_mux2_bus_arbiter: directed scenarios plus random traffic against a transaction-level arbiter model
module tb_mux2_bus_arbiter;
  localparam int W  = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0]  req0_data, req1_data, out_data;
  logic          sel, out_valid, out_src, out_ready;

  always #5 clk = ~clk;

  mux2_bus_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  int checks = 0, errors = 0;

  // model: owner -1 = nobody, cnt = words moved in the current grant
  int           m_own, m_cnt, m_last;
  bit           m_oval, m_osrc;
  logic [W-1:0] m_odata;

  bit           auto_m, collect;
  int           idx0, lim0, idx1, lim1;
  logic [W-1:0] base0, base1;
  logic [W-1:0] got_q[$];

  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_own = -1; m_cnt = 0; m_last = 1; m_oval = 0; m_osrc = 0; m_odata = '0;
  endtask

  task automatic step();
    bit free, r0, r1, a0, a1, myv, othv;
    #1;
    free = !m_oval || out_ready;
    r0 = m_own == 0 && free;
    r1 = m_own == 1 && free;
    check("req0_ready", req0_ready, r0);
    check("req1_ready", req1_ready, r1);
    check("sel", sel, m_own == 1);
    check("out_valid", out_valid, m_oval);
    check("out_data", out_data, m_odata);
    check("out_src", out_src, m_osrc);
    if (collect && out_valid && out_ready) got_q.push_back(out_data);
    a0 = r0 && req0_valid;
    a1 = r1 && req1_valid;
    if (reset) m_reset();
    else begin
      if (a0 || a1) begin
        m_oval = 1; m_odata = a1 ? req1_data : req0_data; m_osrc = a1; m_cnt++;
      end else if (out_ready) m_oval = 0;
      if (m_own < 0) begin
        if (req0_valid && req1_valid) m_own = 1 - m_last;
        else if (req0_valid) m_own = 0;
        else if (req1_valid) m_own = 1;
      end else begin
        myv  = (m_own == 1) ? req1_valid : req0_valid;
        othv = (m_own == 1) ? req0_valid : req1_valid;
        if (!myv || ((a0 || a1) && m_cnt == MB)) begin
          m_last = m_own; m_cnt = 0; m_own = othv ? 1 - m_own : -1;
        end
      end
    end
    @(negedge clk);
    if (a0) idx0++;
    if (a1) idx1++;
    if (auto_m) begin
      if (a0 || !req0_valid) begin req0_valid = $urandom_range(0, 2) != 0; req0_data = $urandom; end
      if (a1 || !req1_valid) begin req1_valid = $urandom_range(0, 2) != 0; req1_data = $urandom; end
      out_ready = $urandom_range(0, 3) != 0;
    end else begin
      req0_valid = idx0 < lim0; req0_data = base0 + W'(idx0);
      req1_valid = idx1 < lim1; req1_data = base1 + W'(idx1);
    end
  endtask

  task automatic src(logic [W-1:0] b0, int l0, logic [W-1:0] b1, int l1);
    base0 = b0; lim0 = l0; idx0 = 0; req0_valid = l0 > 0; req0_data = b0;
    base1 = b1; lim1 = l1; idx1 = 0; req1_valid = l1 > 0; req1_data = b1;
  endtask

  task automatic do_reset();
    reset = 1; auto_m = 0; out_ready = 1;
    src('0, 0, '0, 0);
    @(posedge clk);
    @(negedge clk);
    m_reset();
    reset = 0;
  endtask

  initial begin
    reset = 1; out_ready = 1; collect = 0; auto_m = 0;
    src('0, 0, '0, 0);
    m_reset();
    @(negedge clk);
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_sel", sel, 0);

    src('hA5, 1, '0, 0);
    step(); step();
    check("a5_valid", out_valid, 1);
    check("a5_data", out_data, 'hA5);
    check("a5_src", out_src, 0);
    step();

    do_reset();
    src('h10, 8, 'h20, 8);
    collect = 1;
    repeat (20) step();
    collect = 0;
    check("cont_len", got_q.size(), 16);
    for (int k = 0; k < 16 && k < got_q.size(); k++)
      check("cont_word", got_q[k], ((k / MB) % 2 ? 'h20 : 'h10) + (k / (2 * MB)) * MB + k % MB);

    do_reset();
    src('h30, 1, '0, 0);
    repeat (3) step();
    src('h40, 1, 'h50, 1);
    step();
    check("tie2_sel", sel, 1);
    repeat (4) step();

    do_reset();
    src('0, 0, 'h60, 8);
    repeat (3) step();
    out_ready = 0;
    repeat (3) begin
      step();
      check("bp_hold", out_data, 'h61);
      check("bp_ready", req1_ready, 0);
    end
    out_ready = 1;
    step();
    check("bp_resume", out_data, 'h62);
    repeat (10) step();

    do_reset();
    src('0, 0, 'h80, 2);
    step();
    base0 = 'h70; lim0 = 3; idx0 = 0; req0_valid = 1; req0_data = 'h70;
    repeat (3) step();
    check("drop_sel", sel, 0);
    check("drop_r0", req0_ready, 1);
    repeat (5) step();

    do_reset();
    src('0, 0, 'h90, 4);
    repeat (3) step();
    reset = 1;
    step();
    reset = 0;
    check("mrst_valid", out_valid, 0);
    check("mrst_sel", sel, 0);
    src('hA0, 1, 'hB0, 1);
    step();
    check("mrst_tie", req0_ready, 1);
    repeat (4) step();

    do_reset();
    auto_m = 1;
    repeat (3000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux2_bus_arbiter.md
Name: mux2_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 32-bit 2:1 datapath mux (`mux2`).
- Two requesters, each with a valid/ready handshake, compete for one registered 32-bit output bus.
- The block drives the mux select, gates the requester handshakes, and limits each grant to a bounded burst.
- It sits between two operand/result producers and a single downstream consumer, for example a register-file write port.

Parameters:
- WIDTH, 32, data width; must match the mux2 instance width.
- MAX_BURST, 4, maximum transfers per grant before a forced hand-over (legal range 1-15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has data.
- req0_data  input  WIDTH  requester 0 payload; mux input a.
- req0_ready  output  1  requester 0 transfer accepted this cycle.
- req1_valid  input  1  requester 1 has data.
- req1_data  input  WIDTH  requester 1 payload; mux input b.
- req1_ready  output  1  requester 1 transfer accepted this cycle.
- sel  output  1  mux select: 0 = req0/a, 1 = req1/b.
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered mux output.
- out_src  output  1  requester index of out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Clock and reset:
  - One clock, `clk`. Reset `reset` is synchronous and active-high, and dominates all other inputs.
- Reset values:
  - Outputs: sel=0, out_valid=0, out_data=0, out_src=0.
  - Internal: state=IDLE, burst_cnt=0, last_served=1, so req0 wins the first tie.
  - Reset mid-burst drops any held out_data with no handshake.
- FSM states: IDLE, GRANT0, GRANT1. sel = (state==GRANT1), decoded from the registered state.
- IDLE transitions:
  - Both valid: go to GRANT of the requester != last_served.
  - One valid: go to that requester's GRANT.
  - None valid: stay in IDLE.
  - No ready is asserted in IDLE, so arbitration costs 1 cycle.
- Output-register space: out_free = !out_valid | out_ready.
- GRANTn:
  - reqn_ready = out_free; the other requester's ready = 0.
  - Transfer when reqn_valid & reqn_ready: out_data <= mux2 output, out_src <= n, out_valid <= 1, burst_cnt++.
- Release from GRANTn happens when:
  - reqn_valid=0 (no transfer that cycle), or
  - a transfer occurs with burst_cnt==MAX_BURST-1.
- On release:
  - burst_cnt <= 0 and last_served <= n.
  - Next state is GRANT of the other requester if its valid=1 that cycle, else IDLE.
  - A direct GRANT-to-GRANT hand-over has no bubble.
- Backpressure: when out_valid=1 and out_ready=0, hold out_* and deassert both readies. The FSM stays, burst_cnt holds, and the grant is not released by the stall.
- Output drain: when out_ready=1 with no new transfer, out_valid <= 0.
- Simultaneous drain and load: the register reloads and out_valid stays 1, giving full throughput of 1 word per cycle.
- Latency: reqn_valid rises in IDLE at cycle N -> reqn_ready at N+1 (if out_free) -> out_valid at N+2.
- Fairness: under continuous contention, grants alternate every MAX_BURST transfers, so neither requester waits longer than MAX_BURST+1 cycles after the output frees.
- Requester rule: must hold valid/data stable until ready; the arbiter does not check this.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT0=2'd1, ST_GRANT1=2'd2;
  - default MAX_BURST;
  - burst counter width (4 bits).
- Sub-module: one instance of the existing 32-bit `mux2` datapath cell, with a=req0_data, b=req1_data, s=sel. Its output feeds the out_data register.
- Everything else (FSM, counter, output register) lives in this block.

Test Plan:
- Reset, then req0_valid=1 with req0_data=0x0000_00A5, out_ready=1 -> cycle 1: req0_ready=1, sel=0; cycle 2: out_valid=1, out_data=0x0000_00A5, out_src=0.
- Both valid continuously, req0 data 0x10..0x17, req1 data 0x20..0x27, out_ready=1, MAX_BURST=4 -> output sequence 0x10-0x13, 0x20-0x23, 0x14-0x17, 0x24-0x27, with no bubbles after the first arbitration cycle.
- GRANT1 streaming, out_ready=0 for 3 cycles -> req1_ready=0 and out_data held for 3 cycles, burst_cnt frozen. out_ready=1 then resumes, with the next word on the following edge.
- Tie from IDLE immediately after reset -> req0 granted first. Tie after a req0 grant releases to IDLE -> req1 granted.
- req1 deasserts valid mid-burst after 2 transfers while req0_valid=1 -> next cycle state=GRANT0 and sel=0, with burst_cnt restarting at 0.
- reset asserted while out_valid=1 in GRANT1 -> next cycle out_valid=0, sel=0, state IDLE. A subsequent tie grants req0.
